// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused LSB-first over WIDTH cycles.
// Optional macro SERIAL_ADDER_SUB_EN adds a Sub input that turns the operation into A-B.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] a_sr_r;
  logic [WIDTH-1:0] b_sr_r;
  logic             carry_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] b_load_s;
  logic             c_load_s;
  logic [1:0]       fa_s;

  // Returns {carry_out, sum_bit} of a single full-adder cell.
  function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
    full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

  // Operand B and initial carry as loaded on an accepted start.
  always_comb begin
    b_load_s = B;
    c_load_s = Cin;
`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1, so Cout=1 means no borrow.
    if (Sub) begin
      b_load_s = ~B;
      c_load_s = 1'b1;
    end else begin
      b_load_s = B;
      c_load_s = Cin;
    end
`endif
  end

  // Shared full-adder cell fed by the operand LSBs and the running carry.
  assign fa_s = full_add(a_sr_r[0], b_sr_r[0], carry_r);

  // Controller FSM with datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      a_sr_r  <= '0;
      b_sr_r  <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      Sum     <= '0;
      Cout    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sr_r  <= A;
            b_sr_r  <= b_load_s;
            carry_r <= c_load_s;
            Sum     <= '0;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        RUN: begin
          // Sum bits enter at the MSB; after WIDTH shifts the first bit sits at bit 0.
          Sum     <= {fa_s[0], Sum[WIDTH-1:1]};
          carry_r <= fa_s[1];
          a_sr_r  <= {1'b0, a_sr_r[WIDTH-1:1]};
          b_sr_r  <= {1'b0, b_sr_r[WIDTH-1:1]};
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == LAST_BIT) begin
            Cout    <= fa_s[1];
            busy    <= 1'b0;
            done    <= 1'b1;
            state_r <= DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= RUN;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl: driver pushes expected results, monitor checks on done.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin_in;
  logic             sub_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum_out;
  logic             cout_out;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .start(start), .A(a_in), .B(b_in), .Cin(cin_in),
`ifdef SERIAL_ADDER_SUB_EN
    .Sub(sub_in),
`endif
    .busy(busy), .done(done), .Sum(sum_out), .Cout(cout_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH:0] val;
    int             cyc;
  } exp_t;

  exp_t           sb[$];
  int             total = 0;
  int             bad = 0;
  int             cyc = 0;
  logic [WIDTH:0] last_res;
  bit             hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic logic [WIDTH:0] model(input int a, input int b, input int cin, input int sub);
    int r;
    if (sub != 0) begin
      r = (a - b) & ((1 << WIDTH) - 1);
      if (a >= b) r = r + (1 << WIDTH);
    end else begin
      r = a + b + cin;
    end
    return r[WIDTH:0];
  endfunction

  // Monitor: pops an expectation on every done pulse and checks result hold.
  always @(negedge clk) begin
    if (busy && done) check("busy_done_overlap", 64'd1, 64'd0);
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", {cout_out, sum_out}, e.val);
        check("latency", cyc - e.cyc, WIDTH);
      end
      last_res = {cout_out, sum_out};
      hold = 1'b1;
    end else if (busy) begin
      hold = 1'b0;
    end else if (hold) begin
      check("result_hold", {cout_out, sum_out}, last_res);
    end
  end

  task automatic wait_idle();
    int t = 0;
    while ((busy || done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("done_timeout", 64'd1, 64'd0);
  endtask

  task automatic push_now(input int a, input int b, input int c, input int s);
    exp_t e;
    e.val = model(a, b, c, s);
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  // Issue one operation from IDLE and record its expected result.
  task automatic do_op(input int a, input int b, input int c, input int s);
    wait_idle();
    a_in = a[WIDTH-1:0]; b_in = b[WIDTH-1:0]; cin_in = c[0]; sub_in = s[0];
    start = 1'b1;
    @(posedge clk); #1;
    push_now(a, b, c, s);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
  endtask

  initial begin
    int s;
    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0; sub_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_sum", sum_out, '0);
    check("reset_cout", cout_out, 1'b0);

    do_op(8'h5A, 8'h3C, 0, 0);
    do_op(8'hFF, 8'h01, 0, 0);
    do_op(8'hFF, 8'hFF, 1, 0);

    // Starts during RUN and DONE must be ignored.
    do_op(8'h01, 8'h02, 0, 0);
    repeat (2) @(negedge clk);
    a_in = 8'hF0; b_in = 8'h0F; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);

    // Reset in the middle of RUN aborts without a done pulse.
    wait_idle();
    a_in = 8'hAA; b_in = 8'h55; cin_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_sum", sum_out, '0);
    check("abort_cout", cout_out, 1'b0);
    repeat (14) @(negedge clk);
    do_op(8'h01, 8'h01, 0, 0);

    // Start held high: one acceptance every WIDTH+2 cycles.
    wait_idle();
    a_in = 8'h03; b_in = 8'h04; cin_in = 1'b0; sub_in = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      push_now(8'h03, 8'h04, 0, 0);
      if (k < 2) repeat (WIDTH + 1) @(posedge clk);
    end
    @(negedge clk);
    start = 1'b0;

`ifdef SERIAL_ADDER_SUB_EN
    do_op(8'h10, 8'h01, 0, 1);
    do_op(8'h00, 8'h01, 1, 1);
    do_op(8'h5A, 8'h3C, 0, 0);
`endif

    for (int i = 0; i < 20; i++) begin
      s = 0;
`ifdef SERIAL_ADDER_SUB_EN
      s = int'($urandom_range(0, 1));
`endif
      do_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 1)), s);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
